// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock using a
// trial subtraction (add of the inverted divisor with carry-in 1).
module div_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   partial_q, partial_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             noBorrow;

    // Carry out of the (WIDTH+1)-bit add of ~divisor + 1 means no borrow.
    always_comb begin
        shifted  = {partial_q[WIDTH-1:0], dividend_q[WIDTH-1]};
        trial    = {1'b0, shifted} + {1'b0, ~{1'b0, divisor_q}} + (WIDTH + 2)'(1);
        noBorrow = trial[WIDTH+1];
    end

    always_comb begin
        state_d     = state_q;
        partial_d   = partial_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    dividend_d = A;
                    divisor_d  = B;
                    partial_d  = '0;
                    count_d    = CW'(WIDTH);
                    dbz_d      = 1'b0;
                    if (B == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = A;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                partial_d  = noBorrow ? trial[WIDTH:0] : shifted;
                dividend_d = {dividend_q[WIDTH-2:0], noBorrow};
                count_d    = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d     = DONE;
                    quotient_d  = {dividend_q[WIDTH-2:0], noBorrow};
                    remainder_d = partial_d[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            partial_q   <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            partial_q   <= partial_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table, multi-cycle corner sequences
// and randomized divides against an arithmetic reference model.
module tb_div_seq;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] expQ;
        logic [WIDTH-1:0] expR;
        logic             expDbz;
    } vector_t;

    vector_t vectors[7];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                            output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endtask

    // One complete divide from IDLE: checks latency, busy length, results and
    // that done is a single-cycle pulse.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input string tag);
        logic [WIDTH-1:0] q, r;
        logic z;
        int cyc;
        int busyCnt;
        refModel(a, b, q, r, z);
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        cyc     = 0;
        busyCnt = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busyCnt++;
        end
        checkOutput({tag, "_doneSeen"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_latency"}, cyc, (b == 0) ? 0 : WIDTH);
        checkOutput({tag, "_busyCycles"}, busyCnt, (b == 0) ? 0 : WIDTH);
        checkOutput({tag, "_quotient"}, {16'd0, quotient}, {16'd0, q});
        checkOutput({tag, "_remainder"}, {16'd0, remainder}, {16'd0, r});
        checkOutput({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, z});
        @(posedge clk);
        #1;
        checkOutput({tag, "_donePulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_holdQ"}, {16'd0, quotient}, {16'd0, q});
    endtask

    initial begin
        int doneCount;
        int doneCycle;
        logic [WIDTH-1:0] ra, rb;

        vectors[0] = '{16'd100,    16'd7,      16'd14,     16'd2,  1'b0};
        vectors[1] = '{16'hFFFF,   16'd1,      16'hFFFF,   16'd0,  1'b0};
        vectors[2] = '{16'hFFFF,   16'hFFFF,   16'd1,      16'd0,  1'b0};
        vectors[3] = '{16'd5,      16'd0,      16'hFFFF,   16'd5,  1'b1};
        vectors[4] = '{16'd7,      16'd3,      16'd2,      16'd1,  1'b0};
        vectors[5] = '{16'd3,      16'd10,     16'd0,      16'd3,  1'b0};
        vectors[6] = '{16'd0,      16'd9,      16'd0,      16'd0,  1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_quotient", {16'd0, quotient}, 32'd0);
        checkOutput("reset_remainder", {16'd0, remainder}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_tableQ", i), {16'd0, quotient}, {16'd0, vectors[i].expQ});
            checkOutput($sformatf("vec%0d_tableR", i), {16'd0, remainder}, {16'd0, vectors[i].expR});
            checkOutput($sformatf("vec%0d_tableZ", i), {31'd0, div_by_zero}, {31'd0, vectors[i].expDbz});
        end

        // Start during RUN is ignored; previous result held mid-run.
        @(negedge clk);
        start = 1'b1;
        A     = 16'd1000;
        B     = 16'd3;
        @(posedge clk);
        #1;
        start     = 1'b0;
        doneCount = 0;
        doneCycle = -1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start = 1'b1;
                A     = 16'd9;
                B     = 16'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i == 10) checkOutput("ignore_holdDuringRun", {16'd0, quotient}, 32'd0);
            if (done) begin
                doneCount++;
                doneCycle = i;
            end
        end
        checkOutput("ignore_doneCount", doneCount, 1);
        checkOutput("ignore_doneCycle", doneCycle, WIDTH);
        checkOutput("ignore_quotient", {16'd0, quotient}, 32'd333);
        checkOutput("ignore_remainder", {16'd0, remainder}, 32'd1);

        // Back-to-back: start held in the DONE cycle is accepted.
        @(negedge clk);
        start = 1'b1;
        A     = 16'd100;
        B     = 16'd7;
        @(posedge clk);
        #1;
        A = 16'd50;
        B = 16'd6;
        doneCycle = 0;
        while (!done && doneCycle < 40) begin
            @(posedge clk);
            #1;
            doneCycle++;
        end
        checkOutput("b2b_firstLatency", doneCycle, WIDTH);
        checkOutput("b2b_firstQ", {16'd0, quotient}, 32'd14);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_busyAfterDone", {31'd0, busy}, 32'd1);
        doneCycle = 0;
        while (!done && doneCycle < 40) begin
            @(posedge clk);
            #1;
            doneCycle++;
        end
        checkOutput("b2b_secondLatency", doneCycle, WIDTH);
        checkOutput("b2b_secondQ", {16'd0, quotient}, 32'd8);
        checkOutput("b2b_secondR", {16'd0, remainder}, 32'd2);

        // Asynchronous reset mid-RUN aborts the operation.
        @(negedge clk);
        start = 1'b1;
        A     = 16'd1000;
        B     = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_quotient", {16'd0, quotient}, 32'd0);
        checkOutput("abort_remainder", {16'd0, remainder}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        checkOutput("abort_noDone", doneCount, 0);
        applyStimulus(16'd50, 16'd6, "abort_next");

        // Randomized divides against the reference model.
        for (int i = 0; i < 30; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = WIDTH'($urandom_range(1, 15));
                default: rb = WIDTH'($urandom);
            endcase
            applyStimulus(ra, rb, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
